// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter and output-enable sequencer for a shared tri-state bus.
// Ports: clk, rst (sync, active-high); req/last per agent in;
//        grant/drive_en one-hot out, owner_id, bus_busy, multi_drive_err out.
`timescale 1ns/1ps
module tri_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           last,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           drive_en,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       bus_busy,
    output logic                       multi_drive_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             err_q, err_d;

    // Round-robin pick: rotate req so bit 0 is rr_ptr, take first set bit.
    logic [2*N_REQ-1:0] rot;
    logic               found;
    logic [IW-1:0]      pick;
    int                 sel;

    always_comb begin
        rot   = {req, req} >> rr_ptr_q;
        found = 1'b0;
        pick  = '0;
        sel   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sel   = int'(rr_ptr_q) + i;
                if (sel >= N_REQ) begin
                    sel = sel - N_REQ;
                end
                pick = IW'(sel);
            end
        end
    end

    // Any release condition ends the tenure; they are not cumulative.
    logic rel;
    logic [IW-1:0] next_ptr;

    assign rel = !req[owner_q] || last[owner_q] ||
                 (hold_cnt_q == HW'(MAX_HOLD));
    assign next_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        tcnt_d     = tcnt_q;
        err_d      = err_q | ($countones(grant_q) > 1);
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    grant_d    = N_REQ'(1) << pick;
                    owner_d    = pick;
                    hold_cnt_d = HW'(1);
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    tcnt_d   = TW'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            TURN: begin
                if (tcnt_q < TW'(TURNAROUND)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else if (found) begin
                    state_d    = GRANT;
                    grant_d    = N_REQ'(1) << pick;
                    owner_d    = pick;
                    hold_cnt_d = HW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            tcnt_q     <= tcnt_d;
            err_q      <= err_d;
        end
    end

    assign grant           = grant_q;
    assign drive_en        = grant_q;
    assign owner_id        = owner_q;
    assign bus_busy        = |grant_q;
    assign multi_drive_err = err_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed + random bench for tri_bus_arbiter.
// Expected drive_en values are queued at stimulus time and popped after the edge.
`timescale 1ns/1ps
module tb_tri_bus_arbiter;

    localparam int N = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [N-1:0] grant;
    logic [N-1:0] drive_en;
    logic [1:0]   owner_id;
    logic         bus_busy;
    logic         multi_drive_err;

    int total  = 0;
    int passes = 0;
    logic [N-1:0] expq[$];

    tri_bus_arbiter #(
        .N_REQ(N),
        .MAX_HOLD(MH),
        .TURNAROUND(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .last(last),
        .grant(grant),
        .drive_en(drive_en),
        .owner_id(owner_id),
        .bus_busy(bus_busy),
        .multi_drive_err(multi_drive_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Push the expectation for the coming edge, then pop and compare after it.
    task automatic step(input logic [N-1:0] exp);
        logic [N-1:0] got;
        expq.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        got = expq.pop_front();
        chk("drive_en", 32'(drive_en), 32'(got));
        chk("grant", 32'(grant), 32'(got));
        chk("bus_busy", 32'(bus_busy), 32'(|got));
        chk("multi_drive_err", 32'(multi_drive_err), 0);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst  = 1'b1;
        req  = r;
        last = '0;
        step('0);
        chk("owner_after_rst", 32'(owner_id), 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rq_prev;
        logic [N-1:0] de_prev;
        int run;

        rst  = 1'b1;
        req  = 4'b1111;
        last = '0;

        // Reset held for 3 cycles with all requesting.
        for (int c = 0; c < 3; c++) begin
            step('0);
            chk("rst_owner", 32'(owner_id), 0);
        end

        // All requesting: owners 0,1,2,3,0, 4 cycles each, 1-cycle gaps.
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            logic [N-1:0] e;
            e = (c % 5 < 4) ? N'(1) << ((c / 5) % 4) : '0;
            step(e);
            chk("rr_owner", 32'(owner_id), 32'((c / 5) % 4));
        end

        // Sole requester 2: 4 on, 1 off, repeating.
        do_reset(4'b0100);
        for (int c = 0; c < 15; c++) begin
            step((c % 5 < 4) ? 4'b0100 : 4'b0000);
            chk("sole_owner", 32'(owner_id), 2);
        end

        // last on 2nd grant cycle ends tenure; non-owner last ignored.
        do_reset(4'b0010);
        step(4'b0010);
        step(4'b0010);
        last = 4'b0010;
        step(4'b0000);
        last = 4'b0000;
        step(4'b0010);
        last = 4'b1101;
        step(4'b0010);
        step(4'b0010);
        step(4'b0010);
        step(4'b0000);
        last = '0;

        // Request drop releases immediately, then back to idle.
        do_reset(4'b0001);
        step(4'b0001);
        req = '0;
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);

        // Reset mid-grant clears drive and round-robin pointer.
        do_reset(4'b1000);
        step(4'b1000);
        chk("owner3", 32'(owner_id), 3);
        step(4'b1000);
        rst = 1'b1;
        step(4'b0000);
        chk("owner_rst", 32'(owner_id), 0);
        rst = 1'b0;
        req = 4'b1001;
        step(4'b0001);
        chk("owner_after", 32'(owner_id), 0);

        // Random traffic: structural invariants every cycle.
        do_reset('0);
        de_prev = '0;
        run = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++) begin
                req[b]  = ($urandom_range(0, 3) != 0);
                last[b] = ($urandom_range(0, 7) == 0);
            end
            rq_prev = req;
            @(posedge clk);
            @(negedge clk);
            chk("onehot0", 32'($countones(drive_en) <= 1), 1);
            chk("de_eq_grant", 32'(drive_en), 32'(grant));
            chk("busy_rand", 32'(bus_busy), 32'(|drive_en));
            chk("req_backed",
                32'((drive_en == '0) || ((drive_en & rq_prev) != '0)), 1);
            chk("gap",
                32'((de_prev != '0) && (drive_en != '0) &&
                    (drive_en != de_prev)), 0);
            if (drive_en != '0 && drive_en == de_prev) begin
                run++;
            end else begin
                run = (drive_en != '0) ? 1 : 0;
            end
            chk("hold_max", 32'(run <= MH), 1);
            de_prev = drive_en;
        end
        chk("err_final", 32'(multi_drive_err), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
